// File: rtl/ps2_receiver.sv
`default_nettype none
// ============================================================================
// Module      : ps2_receiver
// Description : PS/2 keyboard frame deserialiser. Synchronises and
//               glitch-filters the raw ps2_clk / ps2_data pins, frames
//               start / 8 data (LSB first) / odd parity / stop, and presents
//               the two most recent good bytes as {previous, newest}.
//               Stalled frames are abandoned after TIMEOUT_CYCLES.
//
// Ports       : clk          - system clock, rising edge
//               rst          - synchronous active-high reset
//               ps2_clk      - raw keyboard clock pin (asynchronous)
//               ps2_data     - raw keyboard data pin (asynchronous)
//               keyboard_out - {previous good byte, newest good byte}
//               byte_valid   - 1-cycle pulse, keyboard_out just updated
//               frame_err    - 1-cycle pulse, frame discarded
//
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] keyboard_out,
    output logic        byte_valid,
    output logic        frame_err
);

    localparam int c_FILT_W = $clog2(FILTER_LEN + 1);
    localparam int c_TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_FILT_W-1:0] c_FILT_LAST = c_FILT_W'(FILTER_LEN - 1);
    localparam logic [c_TO_W-1:0]   c_TO_LAST   = c_TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    // ------------------------------------------------------------------
    // Pin synchronisers (idle-high bus, so reset to 1)
    // ------------------------------------------------------------------
    logic [1:0] r_clk_sync;
    logic [1:0] r_data_sync;
    logic       w_clk_s;
    logic       w_data_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk};
            r_data_sync <= {r_data_sync[0], ps2_data};
        end
    end

    assign w_clk_s  = r_clk_sync[1];
    assign w_data_s = r_data_sync[1];

    // ------------------------------------------------------------------
    // Glitch filter on ps2_clk and falling-edge strobe
    // ------------------------------------------------------------------
    logic [c_FILT_W-1:0] r_filt_cnt;
    logic                r_clk_filt;
    logic                r_clk_filt_q;
    logic                r_fall_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_filt_cnt   <= '0;
            r_clk_filt   <= 1'b1;
            r_clk_filt_q <= 1'b1;
            r_fall_tick  <= 1'b0;
        end else begin
            r_clk_filt_q <= r_clk_filt;
            // Strobe lands in the cycle after the filtered level has gone low.
            r_fall_tick  <= r_clk_filt_q & ~r_clk_filt;
            if (w_clk_s == r_clk_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == c_FILT_LAST) begin
                r_clk_filt <= ~r_clk_filt;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_nxt;
    logic [2:0]        r_bit_cnt;
    logic [2:0]        w_bit_cnt_nxt;
    logic              r_parity;
    logic              w_parity_nxt;
    logic              w_accept;
    logic              w_reject;
    logic [c_TO_W-1:0] r_to_cnt;
    logic [c_TO_W-1:0] w_to_inc;
    logic              w_timeout;

    // The timeout fires on the edge where the counter would reach its last
    // value, so frame_err appears exactly TIMEOUT_CYCLES cycles after the
    // last fall_tick cycle. A coincident fall_tick takes priority.
    assign w_to_inc  = r_to_cnt + 1'b1;
    assign w_timeout = (r_state != S_IDLE) && !r_fall_tick && (w_to_inc == c_TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shift   <= 8'h00;
            r_bit_cnt <= 3'd0;
            r_parity  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_parity  <= w_parity_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_parity_nxt  = r_parity;
        w_accept      = 1'b0;
        w_reject      = 1'b0;

        if (r_fall_tick) begin
            case (r_state)
                S_IDLE: begin
                    // A high start bit is treated as noise, not an error.
                    if (!w_data_s) begin
                        w_state_nxt   = S_DATA;
                        w_bit_cnt_nxt = 3'd0;
                        w_shift_nxt   = 8'h00;
                    end
                end
                S_DATA: begin
                    // Right shift: after 8 bits the first (LSB) bit sits at bit 0.
                    w_shift_nxt   = {w_data_s, r_shift[7:1]};
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = S_PARITY;
                    end
                end
                S_PARITY: begin
                    w_parity_nxt = w_data_s;
                    w_state_nxt  = S_STOP;
                end
                S_STOP: begin
                    w_state_nxt = S_IDLE;
                    if (w_data_s && (^{r_shift, r_parity})) begin
                        w_accept = 1'b1;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end else if (w_timeout) begin
            w_state_nxt = S_IDLE;
            w_reject    = 1'b1;
        end
    end

    // Idle timer only runs while a frame is in progress.
    always_ff @(posedge clk) begin
        if (rst || (r_state == S_IDLE) || r_fall_tick) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= w_to_inc;
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            keyboard_out <= 16'h0000;
            byte_valid   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            byte_valid <= w_accept;
            frame_err  <= w_reject;
            if (w_accept) begin
                keyboard_out <= {keyboard_out[7:0], r_shift};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_receiver
// Description : Scoreboard bench for ps2_receiver. Stimulus drives PS/2
//               frames on the pins and queues the expected output events;
//               a monitor pops and compares on every byte_valid/frame_err.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_receiver;

    localparam int FL   = 8;
    localparam int TO   = 200;
    localparam int HALF = 30;   // PS/2 half period in clk cycles

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] keyboard_out;
    logic        byte_valid;
    logic        frame_err;

    ps2_receiver #(
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .keyboard_out (keyboard_out),
        .byte_valid   (byte_valid),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic rst_q = 1'b1;
    always @(posedge clk) begin
        cyc   = cyc + 1;
        rst_q <= rst;
    end

    typedef struct packed {
        logic        is_err;
        logic [15:0] kb;
    } exp_t;

    exp_t exp_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   last_fall = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic [15:0] last_kb = 16'h0000;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (byte_valid || frame_err) begin
            check("valid_err_exclusive", {31'b0, byte_valid & frame_err}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: byte_valid=%b frame_err=%b keyboard_out=%h, none expected",
                         byte_valid, frame_err, keyboard_out);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_is_err", {31'b0, frame_err}, {31'b0, mon_e.is_err});
                check("keyboard_out", {16'b0, keyboard_out}, {16'b0, mon_e.kb});
            end
        end
        if (!rst_q && !byte_valid && (keyboard_out !== last_kb)) begin
            checks++;
            failures++;
            $display("FAIL kb_stability: got %h expected %h (no byte_valid)", keyboard_out, last_kb);
        end
        last_kb = keyboard_out;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        tick(HALF / 2);
        ps2_clk   = 1'b0;
        last_fall = cyc;
        tick(HALF);
        ps2_clk = 1'b1;
        tick(HALF / 2);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(p);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        tick(40);
    endtask

    task automatic expect_byte(input logic [15:0] kb);
        exp_q.push_back('{is_err: 1'b0, kb: kb});
    endtask

    task automatic expect_err(input logic [15:0] kb);
        exp_q.push_back('{is_err: 1'b1, kb: kb});
    endtask

    task automatic drain(input string name);
        tick(50);
        check(name, exp_q.size(), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int n;
        logic [7:0] part;

        rst = 1'b1;
        tick(3);
        check("reset_kb", {16'b0, keyboard_out}, 32'h0000);
        check("reset_valid", {31'b0, byte_valid}, 32'd0);
        check("reset_err", {31'b0, frame_err}, 32'd0);
        rst = 1'b0;
        tick(10);

        // Single frame
        expect_byte(16'h001C);
        send_frame(8'h1C, 1'b0);
        drain("single_frame_drain");

        // Break sequence from a clean reset
        pulse_reset();
        tick(5);
        expect_byte(16'h00F0);
        send_frame(8'hF0, 1'b1);
        expect_byte(16'hF01C);
        send_frame(8'h1C, 1'b0);
        drain("break_drain");

        // Parity error, then the same byte with good parity
        expect_err(16'hF01C);
        send_frame(8'h5A, 1'b0);
        expect_byte(16'h1C5A);
        send_frame(8'h5A, 1'b1);
        drain("parity_drain");

        // Short low glitch on ps2_clk while idle with data low
        ps2_data = 1'b0;
        tick(5);
        ps2_clk = 1'b0;
        tick(FL - 2);
        ps2_clk = 1'b1;
        tick(20);
        ps2_data = 1'b1;
        tick(20);
        expect_byte(16'h5A45);
        send_frame(8'h45, 1'b0);
        drain("glitch_drain");

        // Stalled frame: start + 4 data bits, then clock held high
        expect_err(16'h5A45);
        part = 8'h16;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(part[i]);
        n = 0;
        while (!frame_err && n < 2 * TO) begin
            @(negedge clk);
            n++;
        end
        if (frame_err) begin
            check("timeout_latency", cyc - last_fall, 2 + FL + 1 + TO);
        end else begin
            checks++;
            failures++;
            $display("FAIL timeout_wait: got no frame_err expected one within %0d cycles", 2 * TO);
        end
        tick(10);
        expect_byte(16'h4516);
        send_frame(8'h16, 1'b0);
        drain("timeout_drain");

        // Reset after the 5th data bit of a frame
        part = 8'hAA;
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(part[i]);
        tick(5);
        pulse_reset();
        tick(1);
        check("midreset_kb", {16'b0, keyboard_out}, 32'h0000);
        check("midreset_valid", {31'b0, byte_valid}, 32'd0);
        check("midreset_err", {31'b0, frame_err}, 32'd0);
        ps2_data = 1'b1;
        tick(40);
        expect_byte(16'h0066);
        send_frame(8'h66, 1'b1);
        drain("midreset_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog
    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: got timeout expected sequence completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/ps2_receiver.md
# ps2_receiver

Deserialises PS/2 keyboard frames (start, 8 data bits LSB first, odd parity, stop) from the raw `ps2_clk`/`ps2_data` pins. It presents the two most recent good scan-code bytes as `keyboard_out = {previous byte, newest byte}`. It sits directly upstream of the keyboard-to-hex-entry stage, which reads `keyboard_out[15:8] == 8'hF0` as a break (key-release) marker and `keyboard_out[7:0]` as the key code. The block handles pin synchronisation, glitch filtering, frame checking and stalled-frame recovery.

## Interface
- `FILTER_LEN`, default 8: number of consecutive identical synchronised `ps2_clk` samples required before the filtered level changes.
- `TIMEOUT_CYCLES`, default 100000: `clk` cycles without a `ps2_clk` falling edge, while mid-frame, before the frame is abandoned (1 ms at 100 MHz).
- `clk` input 1: system clock; all logic on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `ps2_clk` input 1: raw keyboard clock pin, asynchronous.
- `ps2_data` input 1: raw keyboard data pin, asynchronous.
- `keyboard_out` output 16: `{previous good byte, newest good byte}`.
- `byte_valid` output 1: one-cycle pulse when `keyboard_out` has just been updated.
- `frame_err` output 1: one-cycle pulse when a frame is discarded (parity error, bad stop bit, or timeout).

## Operation
- **Synchronisation:**
  - `ps2_clk` and `ps2_data` each pass through a 2-flop synchroniser.
- **Glitch filter:**
  - A counter tracks consecutive synchronised `ps2_clk` samples that differ from the filtered level.
  - When the count reaches `FILTER_LEN`, the filtered level flips and the counter clears.
  - Any sample equal to the filtered level clears the counter.
  - The filtered level resets to 1.
- **`fall_tick`:** a one-cycle internal strobe, asserted in the cycle after the filtered level goes 1→0. Synchronised `ps2_data` is sampled on `fall_tick`.
- **State machine** (`IDLE`, `DATA`, `PARITY`, `STOP`):
  - `IDLE`, `fall_tick`, data=0: go to `DATA`; clear bit counter and shift register.
  - `IDLE`, `fall_tick`, data=1: stay in `IDLE`. This is a spurious start and is not an error.
  - `DATA`, `fall_tick`: shift the data bit in at bit[7] (right shift, so LSB-first arrives in order) and increment the 3-bit counter. After the 8th bit (counter wraps 7→0), go to `PARITY`.
  - `PARITY`, `fall_tick`: store the bit and go to `STOP`.
  - `STOP`, `fall_tick`: accept the frame when the stop bit is 1 and XOR(data byte, parity bit) = 1. Otherwise raise `frame_err`. Go to `IDLE` in both cases.
- **Frame accept:** `keyboard_out <= {keyboard_out[7:0], byte}` and `byte_valid <= 1`, both on the same edge. Discarded frames leave `keyboard_out` unchanged.
- **Timeout:**
  - The idle counter clears on every `fall_tick` and whenever the state is `IDLE`.
  - In any non-`IDLE` state, when the counter reaches `TIMEOUT_CYCLES-1`: go to `IDLE` and pulse `frame_err`.
  - If a `fall_tick` arrives in that same cycle, the `fall_tick` wins and the counter clears.
- **No protocol decoding:** no host-to-device transmission and no interpretation of scan codes. `F0`/`E0` bytes are delivered like any other byte.

## Timing
- **Reset values:** `keyboard_out` = 16'h0000, `byte_valid` = 0, `frame_err` = 0, state = `IDLE`. Filter, synchroniser and timeout counters are cleared; the filtered level and synchroniser flops are set to 1.
- **Reset mid-frame:** the partial frame is dropped with no `frame_err`. The next complete frame after reset deasserts is received normally.
- **Latency:** `ps2_clk` pin falling edge → `fall_tick` = 2 (sync) + `FILTER_LEN` + 1 cycles.
- **Outputs:** `byte_valid`/`frame_err` assert in the cycle after the stop-bit `fall_tick` and are high for exactly one cycle. They are never high together.
- **Output stability:** `keyboard_out` changes only on a `byte_valid` edge and holds otherwise. Downstream may sample it at any time.
- **Edge spacing:** a minimum of `FILTER_LEN` + 2 cycles between `ps2_clk` edges is needed for detection. PS/2 (10–16.7 kHz) is far above this at any practical `clk`.
- **Back-to-back frames:** a new start bit one PS/2 clock after the stop bit is accepted.

## Test plan
- **Single frame:** reset, then send byte 0x1C (parity 0, stop 1). Required: exactly one `byte_valid` pulse, `keyboard_out` = 16'h001C, `frame_err` never high.
- **Break sequence:** send 0xF0 then 0x1C (parity 1, then 0). Required: after the first pulse `keyboard_out` = 16'h00F0; after the second `keyboard_out` = 16'hF01C.
- **Parity error:**
  - After the break sequence, send 0x5A with parity bit 0 (correct is 1). Required: one `frame_err` pulse, no `byte_valid`, `keyboard_out` stays 16'hF01C.
  - Then send 0x5A with parity 1. Required: `keyboard_out` = 16'h1C5A.
- **Glitch filter:** pulse `ps2_clk` low for `FILTER_LEN`-2 cycles while `IDLE` with `ps2_data`=0, then send a valid frame 0x45. Required: no start detected from the glitch, `keyboard_out[7:0]` = 8'h45.
- **Timeout recovery:**
  - Send the start bit plus 4 data bits, then hold `ps2_clk` high. Required: `frame_err` pulses exactly `TIMEOUT_CYCLES` cycles after the last `fall_tick` (test with `TIMEOUT_CYCLES` = 200).
  - Then send frame 0x16. Required: `keyboard_out[7:0]` = 8'h16.
- **Reset mid-frame:** assert `rst` for one cycle after the 5th data bit of a frame. Required: outputs return to reset values and no `frame_err`. A subsequent frame 0x66 yields `keyboard_out` = 16'h0066.
